packet_match_engine: RTL

//  Ingress stage directly upstream of the packet transmitter. Accepts AXI-Stream frames from the CMAC RX
//  and writes every beat into the shared packet RAM. It checks the first beat (Eth/IPv4/L4 header) against
//  a small programmable rule table. A matching frame yields one match descriptor {addr, pkt_len}; a
//  non-matching frame is discarded by rewinding the RAM write pointer.

---
 rtl/packet_match_pkg.sv | 31 +++
 rtl/header_rule_lookup.sv | 39 +++
 rtl/packet_match_engine.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_match_pkg.sv
// Shared types and header offsets for the packet match engine.
package packet_match_pkg;

  typedef struct packed {
    logic        valid;
    logic [7:0]  proto;
    logic [15:0] dst_port;
  } rule_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_DROP  = 2'd2,
    S_MATCH = 2'd3
  } state_t;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam int          OFF_ETYPE      = 12;
  localparam int          OFF_PROTO      = 23;
  localparam int          OFF_DPORT      = 36;
  localparam int          HDR_BYTES      = OFF_DPORT + 2;

  function automatic logic [15:0] be16(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/header_rule_lookup.sv
// Combinational first-beat header extract (Eth/IPv4/L4) compared against the rule table.
module header_rule_lookup
  import packet_match_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = 64,
  parameter int NUM_RULES  = 4
) (
  input  logic [DATA_WIDTH-1:0]  tdata_i,
  input  logic [KEEP_WIDTH-1:0]  tkeep_i,
  input  rule_t [NUM_RULES-1:0]  rules_i,
  output logic                   hit_o
);

  logic [15:0] etype_s;
  logic [7:0]  proto_s;
  logic [15:0] dport_s;
  logic        hdr_ok_s;
  logic        unused_bits_s;

  // Multi-byte fields arrive big-endian: the lower byte index is the MSB.
  assign etype_s  = be16(tdata_i[OFF_ETYPE*8 +: 8], tdata_i[(OFF_ETYPE+1)*8 +: 8]);
  assign proto_s  = tdata_i[OFF_PROTO*8 +: 8];
  assign dport_s  = be16(tdata_i[OFF_DPORT*8 +: 8], tdata_i[(OFF_DPORT+1)*8 +: 8]);
  assign hdr_ok_s = (&tkeep_i[HDR_BYTES-1:0]) && (etype_s == ETHERTYPE_IPV4);

  assign unused_bits_s = ^{tdata_i, tkeep_i};

  // OR of all enabled rules whose protocol and port both match
  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < NUM_RULES; i++) begin
      hit_o = hit_o | (hdr_ok_s && rules_i[i].valid &&
                       (rules_i[i].proto == proto_s) &&
                       (rules_i[i].dst_port == dport_s));
    end
  end

endmodule

// File: rtl/packet_match_engine.sv
// Ingress match engine: stores RX beats into packet RAM, issues {addr,len} for matching frames,
// rewinds the write pointer for dropped ones. Define MATCH_STATS_EN to build the stat counters.
module packet_match_engine
  import packet_match_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = 64,
  parameter int BUF_ADDR_WIDTH  = 8,
  parameter int MAX_PKT_BEATS   = 128,
  parameter int NUM_RULES       = 4
) (
  input  logic                         clock_i,
  input  logic                         reset_ni,
  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  input  logic                         cfg_wr_en,
  input  logic [$clog2(NUM_RULES)-1:0] cfg_idx,
  input  logic                         cfg_rule_valid,
  input  logic [7:0]                   cfg_proto,
  input  logic [15:0]                  cfg_dst_port,
  output logic                         buf_wr_en,
  output logic [BUF_ADDR_WIDTH-1:0]    buf_wr_addr,
  output logic [AXIS_DATA_WIDTH-1:0]   buf_wr_data,
  output logic                         m_match_valid,
  input  logic                         m_match_ready,
  output logic [BUF_ADDR_WIDTH-1:0]    m_match_addr,
  output logic [15:0]                  m_match_pkt_len,
  output logic [31:0]                  stat_rx_pkts,
  output logic [31:0]                  stat_match_pkts,
  output logic [31:0]                  stat_drop_pkts
);

  localparam logic [BUF_ADDR_WIDTH-1:0] PTR_ONE   = BUF_ADDR_WIDTH'(1);
  localparam logic [15:0]               MAX_BEATS = 16'(MAX_PKT_BEATS);

  state_t                       state_q, state_d;
  logic [BUF_ADDR_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
  logic [BUF_ADDR_WIDTH-1:0]    base_ptr_q, base_ptr_d;
  logic [15:0]                  beat_cnt_q, beat_cnt_d;
  logic                         hit_q, hit_d;
  rule_t [NUM_RULES-1:0]        rules_q, rules_d;
  logic                         buf_wr_en_q, buf_wr_en_d;
  logic [BUF_ADDR_WIDTH-1:0]    buf_wr_addr_q, buf_wr_addr_d;
  logic [AXIS_DATA_WIDTH-1:0]   buf_wr_data_q, buf_wr_data_d;
  logic                         match_valid_q, match_valid_d;
  logic [BUF_ADDR_WIDTH-1:0]    match_addr_q, match_addr_d;
  logic [15:0]                  match_len_q, match_len_d;

  logic                         accept_s;
  logic                         lookup_hit_s;
  logic                         drop_s;
  logic                         handshake_s;
  logic [15:0]                  beat_next_s;

  assign s_axis_tready = reset_ni && (state_q != S_MATCH);
  assign accept_s      = s_axis_tvalid && s_axis_tready;
  assign handshake_s   = match_valid_q && m_match_ready;
  assign beat_next_s   = beat_cnt_q + 16'd1;

  // Lookup sees the registered table, so a cfg write alongside a first beat applies from the next frame.
  header_rule_lookup #(
    .DATA_WIDTH (AXIS_DATA_WIDTH),
    .KEEP_WIDTH (AXIS_KEEP_WIDTH),
    .NUM_RULES  (NUM_RULES)
  ) u_lookup (
    .tdata_i (s_axis_tdata),
    .tkeep_i (s_axis_tkeep),
    .rules_i (rules_q),
    .hit_o   (lookup_hit_s)
  );

  // Rule table update
  always_comb begin
    rules_d = rules_q;
    if (cfg_wr_en) begin
      rules_d[cfg_idx].valid    = cfg_rule_valid;
      rules_d[cfg_idx].proto    = cfg_proto;
      rules_d[cfg_idx].dst_port = cfg_dst_port;
    end else begin
      rules_d = rules_q;
    end
  end

  // Frame FSM, RAM write port and descriptor next-state
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    base_ptr_d    = base_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    hit_d         = hit_q;
    buf_wr_en_d   = 1'b0;
    buf_wr_addr_d = buf_wr_addr_q;
    buf_wr_data_d = buf_wr_data_q;
    match_valid_d = match_valid_q;
    match_addr_d  = match_addr_q;
    match_len_d   = match_len_q;
    drop_s        = 1'b0;

    if (accept_s && (state_q != S_DROP)) begin
      buf_wr_en_d   = 1'b1;
      buf_wr_addr_d = wr_ptr_q;
      buf_wr_data_d = s_axis_tdata;
      wr_ptr_d      = wr_ptr_q + PTR_ONE;
    end else begin
      buf_wr_en_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          base_ptr_d = wr_ptr_q;
          beat_cnt_d = 16'd1;
          hit_d      = lookup_hit_s;
          if (s_axis_tlast && lookup_hit_s) begin
            state_d       = S_MATCH;
            match_valid_d = 1'b1;
            match_addr_d  = wr_ptr_q;
            match_len_d   = 16'd1;
          end else if (s_axis_tlast) begin
            wr_ptr_d = wr_ptr_q;
            drop_s   = 1'b1;
          end else if (MAX_BEATS == 16'd1) begin
            state_d = S_DROP;
          end else begin
            state_d = S_RECV;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RECV: begin
        if (accept_s) begin
          beat_cnt_d = beat_next_s;
          if (s_axis_tlast && hit_q) begin
            state_d       = S_MATCH;
            match_valid_d = 1'b1;
            match_addr_d  = base_ptr_q;
            match_len_d   = beat_next_s;
          end else if (s_axis_tlast) begin
            state_d  = S_IDLE;
            wr_ptr_d = base_ptr_q;
            drop_s   = 1'b1;
          end else if (beat_next_s == MAX_BEATS) begin
            state_d = S_DROP;
          end else begin
            state_d = S_RECV;
          end
        end else begin
          state_d = S_RECV;
        end
      end
      S_DROP: begin
        if (accept_s && s_axis_tlast) begin
          state_d  = S_IDLE;
          wr_ptr_d = base_ptr_q;
          drop_s   = 1'b1;
        end else begin
          state_d = S_DROP;
        end
      end
      S_MATCH: begin
        if (handshake_s) begin
          state_d       = S_IDLE;
          match_valid_d = 1'b0;
        end else begin
          state_d = S_MATCH;
        end
      end
      default: begin
        state_d       = S_IDLE;
        match_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      base_ptr_q    <= '0;
      beat_cnt_q    <= 16'd0;
      hit_q         <= 1'b0;
      rules_q       <= '0;
      buf_wr_en_q   <= 1'b0;
      buf_wr_addr_q <= '0;
      buf_wr_data_q <= '0;
      match_valid_q <= 1'b0;
      match_addr_q  <= '0;
      match_len_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      base_ptr_q    <= base_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      hit_q         <= hit_d;
      rules_q       <= rules_d;
      buf_wr_en_q   <= buf_wr_en_d;
      buf_wr_addr_q <= buf_wr_addr_d;
      buf_wr_data_q <= buf_wr_data_d;
      match_valid_q <= match_valid_d;
      match_addr_q  <= match_addr_d;
      match_len_q   <= match_len_d;
    end
  end

  assign buf_wr_en       = buf_wr_en_q;
  assign buf_wr_addr     = buf_wr_addr_q;
  assign buf_wr_data     = buf_wr_data_q;
  assign m_match_valid   = match_valid_q;
  assign m_match_addr    = match_addr_q;
  assign m_match_pkt_len = match_len_q;

`ifdef MATCH_STATS_EN
  logic [31:0] stat_rx_q, stat_rx_d;
  logic [31:0] stat_match_q, stat_match_d;
  logic [31:0] stat_drop_q, stat_drop_d;

  // Saturating event counters
  always_comb begin
    stat_rx_d    = (accept_s && s_axis_tlast) ? sat_inc32(stat_rx_q) : stat_rx_q;
    stat_match_d = handshake_s ? sat_inc32(stat_match_q) : stat_match_q;
    stat_drop_d  = drop_s ? sat_inc32(stat_drop_q) : stat_drop_q;
  end

  // Counter registers
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      stat_rx_q    <= 32'd0;
      stat_match_q <= 32'd0;
      stat_drop_q  <= 32'd0;
    end else begin
      stat_rx_q    <= stat_rx_d;
      stat_match_q <= stat_match_d;
      stat_drop_q  <= stat_drop_d;
    end
  end

  assign stat_rx_pkts    = stat_rx_q;
  assign stat_match_pkts = stat_match_q;
  assign stat_drop_pkts  = stat_drop_q;
`else
  assign stat_rx_pkts    = 32'd0;
  assign stat_match_pkts = 32'd0;
  assign stat_drop_pkts  = 32'd0;
`endif

endmodule
